multi_cycle_control: RTL and testbench
======================================

// Module: multi_cycle_control
// PURPOSE
//  Moore FSM sequencing a multi-cycle MIPS datapath (shared memory, IR, ALU, PC).
//  Decodes Op_i from the IR and drives every datapath mux and write-enable, one
//  phase per cycle, with stall on a memory ready handshake.
//  Covers R-type, addi, lw, sw, beq and j.
//  Also counts retired instructions.
// PARAMETERS
//  CNT_W   32   width of InstrCount_o
// PORTS
//  clk_i          in   1      clock, rising edge
//  rst_n_i        in   1      reset, synchronous, active-low
//  Op_i           in   6      opcode field of IR
//  MemReady_i     in   1      memory access completes this cycle
//  PCWrite_o      out  1      unconditional PC write
//  PCWriteCond_o  out  1      PC write if ALU zero
//  PCSource_o     out  2      00 ALU result, 01 ALUOut, 10 jump target
//  IorD_o         out  1      memory address: 0 PC, 1 ALUOut
//  MemRead_o      out  1      memory read request
//  MemWrite_o     out  1      memory write request
//  IRWrite_o      out  1      IR load
//  MemToReg_o     out  1      reg write data: 0 ALUOut, 1 MDR
//  RegDst_o       out  1      dest reg: 0 rt, 1 rd
//  RegWrite_o     out  1      register file write
//  ALUSrcA_o      out  1      0 PC, 1 A
//  ALUSrcB_o      out  2      00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
//  ALUOp_o        out  2      00 add, 01 sub, 11 funct-decode
//  State_o        out  4      current state encoding (debug)
//  InstrCount_o   out  CNT_W  retired instruction count
//  Trap_o         out  1      illegal opcode trap (RV_TRAP_EN only, else tied 0)
// BEHAVIOUR
//  - Outputs decode from state only, except the FETCH/MEMRD/MEMWR strobes noted below.
//  - Any output not listed for a state is 0. No x outputs in any state.
//  - Synchronous reset: rst_n_i=0 at a clk edge -> state FETCH, op_q 0, InstrCount_o 0, Trap_o 0.
//  - PCWrite/PCWriteCond/IRWrite/RegWrite/MemWrite are forced 0 combinationally while rst_n_i=0.
//    A write phase cut by reset therefore never commits.
//  - Opcodes: 000000 R, 001000 addi, 100011 lw, 101011 sw, 000100 beq, 000010 j.
//  - op_q latches Op_i in DECODE. Later states dispatch on op_q.
//  - States, encodings and outputs:
//   0 FETCH:  MemRead=1, ALUSrcB=01, ALUOp=00, IRWrite=PCWrite=MemReady_i.
//             Stay while !MemReady_i, else -> DECODE.
//   1 DECODE: ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
//             Next state by Op_i: lw/sw -> MEMADR, R -> EXEC, addi -> ADDIEX,
//             beq -> BRANCH, j -> JUMP, other -> see CONFIGURATION.
//   2 MEMADR: ALUSrcA=1, ALUSrcB=10. Next: lw -> MEMRD, sw -> MEMWR.
//   3 MEMRD:  IorD=1, MemRead=1. Stay while !MemReady_i, else -> MEMWB.
//   4 MEMWB:  MemToReg=1, RegWrite=1. Next -> FETCH.
//   5 MEMWR:  IorD=1, MemWrite=1, held through wait cycles. On MemReady_i -> FETCH.
//   6 EXEC:   ALUSrcA=1, ALUSrcB=00, ALUOp=11. Next -> RWB.
//   7 RWB:    RegDst=1, RegWrite=1. Next -> FETCH.
//   8 BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Next -> FETCH.
//   9 JUMP:   PCWrite=1, PCSource=10. Next -> FETCH.
//   10 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next -> ADDIWB.
//   11 ADDIWB: RegWrite=1. Next -> FETCH.
//   12 TRAP:  Trap_o=1.
//  - Latency (cycles, zero wait states): lw 5; sw, R, addi 4; beq, j 3.
//    Each MemReady_i=0 cycle adds 1.
//  - InstrCount_o increments by 1 on each transition into FETCH from MEMWB, MEMWR,
//    RWB, BRANCH, JUMP or ADDIWB. It wraps modulo 2^CNT_W.
//  - Unused encodings 13-15 -> FETCH on the next edge. They are not counted.
// CONFIGURATION
//  RV_TRAP_EN defined:
//   - Illegal opcode in DECODE -> TRAP.
//   - TRAP holds Trap_o=1 with all strobes 0 until reset. Not counted.
//  RV_TRAP_EN undefined:
//   - Illegal opcode -> FETCH; the instruction retires as a NOP and is counted.
//   - Trap_o is tied 0 and state 12 is unreachable.
// TESTING
//  T1: reset low for 2 edges, then high; MemReady_i=1 -> State_o=0, PCWrite_o=1,
//      IRWrite_o=1, InstrCount_o=0.
//  T2: Op_i=100011, MemReady_i=1 -> states 0,1,2,3,4,0; RegWrite_o only in state 4
//      with MemToReg_o=1; count 0->1.
//  T3: Op_i=101011, MemReady_i low 3 cycles in MEMWR -> MemWrite_o=1 for 4 cycles,
//      IorD_o=1; count +1 on the ready cycle.
//  T4: Op_i=000000 then 001000 then 000100 then 000010 -> ALUOp 11/00/01;
//      PCSource 01 in BRANCH and 10 in JUMP; count reaches 4.
//  T5: Op_i=111111 -> with RV_TRAP_EN, State_o=12 and Trap_o=1 held 10 cycles,
//      count unchanged. Without it -> FETCH and count +1.
//  T6: rst_n_i low while in MEMWR with MemReady_i=1 -> MemWrite_o=0 that cycle,
//      next State_o=0, InstrCount_o=0.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Moore control FSM for a multi-cycle MIPS datapath (R-type, addi, lw, sw, beq, j)
// with a retired-instruction counter. Define RV_TRAP_EN to trap on illegal opcodes.
module multi_cycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [5:0]       Op_i,
  input  logic             MemReady_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic [1:0]       PCSource_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemToReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [1:0]       ALUOp_o,
  output logic [3:0]       State_o,
  output logic [CNT_W-1:0] InstrCount_o,
  output logic             Trap_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] instr_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= S_FETCH;
      op_q      <= '0;
      instr_cnt <= '0;
    end else begin
      case (state)
        S_FETCH:  if (MemReady_i) state <= S_DECODE;
        S_DECODE: begin
          op_q <= Op_i;
          case (Op_i)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXEC;
            OP_ADDI:      state <= S_ADDIEX;
            OP_BEQ:       state <= S_BRANCH;
            OP_J:         state <= S_JUMP;
            default: begin
`ifdef RV_TRAP_EN
              state <= S_TRAP;
`else
              // Illegal opcode retires as a NOP.
              state     <= S_FETCH;
              instr_cnt <= instr_cnt + CNT_W'(1);
`endif
            end
          endcase
        end
        S_MEMADR: begin
          if (op_q == OP_SW)      state <= S_MEMWR;
          else if (op_q == OP_LW) state <= S_MEMRD;
          else                    state <= S_FETCH;
        end
        S_MEMRD:  if (MemReady_i) state <= S_MEMWB;
        S_MEMWR: begin
          if (MemReady_i) begin
            state     <= S_FETCH;
            instr_cnt <= instr_cnt + CNT_W'(1);
          end
        end
        S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
          state     <= S_FETCH;
          instr_cnt <= instr_cnt + CNT_W'(1);
        end
        S_EXEC:   state <= S_RWB;
        S_ADDIEX: state <= S_ADDIWB;
`ifdef RV_TRAP_EN
        S_TRAP:   state <= S_TRAP;
`else
        S_TRAP:   state <= S_FETCH;
`endif
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite_o     = 1'b0;
    PCWriteCond_o = 1'b0;
    PCSource_o    = 2'b00;
    IorD_o        = 1'b0;
    MemRead_o     = 1'b0;
    MemWrite_o    = 1'b0;
    IRWrite_o     = 1'b0;
    MemToReg_o    = 1'b0;
    RegDst_o      = 1'b0;
    RegWrite_o    = 1'b0;
    ALUSrcA_o     = 1'b0;
    ALUSrcB_o     = 2'b00;
    ALUOp_o       = 2'b00;
    case (state)
      S_FETCH: begin
        MemRead_o = 1'b1;
        ALUSrcB_o = 2'b01;
        IRWrite_o = MemReady_i;
        PCWrite_o = MemReady_i;
      end
      S_DECODE: ALUSrcB_o = 2'b11;
      S_MEMADR: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      S_MEMRD: begin
        IorD_o    = 1'b1;
        MemRead_o = 1'b1;
      end
      S_MEMWB: begin
        MemToReg_o = 1'b1;
        RegWrite_o = 1'b1;
      end
      S_MEMWR: begin
        IorD_o     = 1'b1;
        MemWrite_o = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA_o = 1'b1;
        ALUOp_o   = 2'b11;
      end
      S_RWB: begin
        RegDst_o   = 1'b1;
        RegWrite_o = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA_o     = 1'b1;
        ALUOp_o       = 2'b01;
        PCWriteCond_o = 1'b1;
        PCSource_o    = 2'b01;
      end
      S_JUMP: begin
        PCWrite_o  = 1'b1;
        PCSource_o = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA_o = 1'b1;
        ALUSrcB_o = 2'b10;
      end
      S_ADDIWB: RegWrite_o = 1'b1;
      default: ;
    endcase
    // A write phase interrupted by reset must not commit.
    if (!rst_n_i) begin
      PCWrite_o     = 1'b0;
      PCWriteCond_o = 1'b0;
      IRWrite_o     = 1'b0;
      RegWrite_o    = 1'b0;
      MemWrite_o    = 1'b0;
    end
  end

  assign State_o      = state;
  assign InstrCount_o = instr_cnt;
`ifdef RV_TRAP_EN
  assign Trap_o = (state == S_TRAP);
`else
  assign Trap_o = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: per-cycle expected state/count queued with
// the stimulus, plus inline strobe checks. Counter width is 3 so wrap-around is reached.
module tb_multi_cycle_control;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [5:0]       op;
  logic             mem_ready;
  logic             PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o;
  logic             MemToReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, Trap_o;
  logic [1:0]       PCSource_o, ALUSrcB_o, ALUOp_o;
  logic [3:0]       State_o;
  logic [CNT_W-1:0] InstrCount_o;

  typedef struct packed {
    logic [3:0]       st;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cnt_base = 0;

  multi_cycle_control #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .Op_i(op), .MemReady_i(mem_ready),
    .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .PCSource_o(PCSource_o),
    .IorD_o(IorD_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
    .IRWrite_o(IRWrite_o), .MemToReg_o(MemToReg_o), .RegDst_o(RegDst_o),
    .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o),
    .ALUOp_o(ALUOp_o), .State_o(State_o), .InstrCount_o(InstrCount_o), .Trap_o(Trap_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0; op = 6'b000000; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_checks++;
    if (State_o !== 4'd0 || InstrCount_o !== '0)
      $display("FAIL reset_state: state=%0d cnt=%0d, want 0/0", State_o, InstrCount_o);
    else n_pass++;
    n_checks++;
    if (PCWrite_o !== 1'b0 || IRWrite_o !== 1'b0)
      $display("FAIL reset_gate: pcw=%b irw=%b, want 0/0", PCWrite_o, IRWrite_o);
    else n_pass++;
    rst_n = 1'b1; #1;
    n_checks++;
    if (PCWrite_o !== 1'b1 || IRWrite_o !== 1'b1 || State_o !== 4'd0 || InstrCount_o !== '0)
      $display("FAIL reset_release: pcw=%b irw=%b state=%0d cnt=%0d, want 1/1/0/0",
               PCWrite_o, IRWrite_o, State_o, InstrCount_o);
    else n_pass++;
    mem_ready = 1'b0;
    cnt_base = 0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    int sts[$]; int rdy[$]; int dc[$]; exp_t e;
    sts = '{0, 1, 2, 3, 4, 0};
    rdy = '{1, 1, 1, 1, 1, 0};
    dc  = '{0, 0, 0, 0, 0, 1};
    op = 6'b100011;
    foreach (sts[i]) begin
      mem_ready = rdy[i][0];
      sb.push_back(exp_t'{st: 4'(sts[i]), cnt: CNT_W'(cnt_base + dc[i])});
      #1;
      e = sb.pop_front();
      n_checks++;
      if (State_o !== e.st || InstrCount_o !== e.cnt)
        $display("FAIL lw_seq step%0d: state=%0d cnt=%0d, want %0d/%0d", i, State_o, InstrCount_o, e.st, e.cnt);
      else n_pass++;
      n_checks++;
      if (RegWrite_o !== (sts[i] == 4) || (sts[i] == 4 && MemToReg_o !== 1'b1))
        $display("FAIL lw_wb step%0d: regwrite=%b memtoreg=%b, want %b/1", i, RegWrite_o, MemToReg_o, sts[i] == 4);
      else n_pass++;
      if (sts[i] == 3) begin
        n_checks++;
        if (MemRead_o !== 1'b1 || IorD_o !== 1'b1)
          $display("FAIL lw_memrd: memread=%b iord=%b, want 1/1", MemRead_o, IorD_o);
        else n_pass++;
      end
      @(negedge clk);
    end
    cnt_base += 1;
  endtask

  task automatic test_sw_wait();
    int sts[$]; int rdy[$]; int dc[$]; exp_t e; int mw_cycles;
    sts = '{0, 0, 0, 1, 2, 5, 5, 5, 5, 0};
    rdy = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0};
    dc  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    op = 6'b101011;
    mw_cycles = 0;
    foreach (sts[i]) begin
      mem_ready = rdy[i][0];
      sb.push_back(exp_t'{st: 4'(sts[i]), cnt: CNT_W'(cnt_base + dc[i])});
      #1;
      e = sb.pop_front();
      n_checks++;
      if (State_o !== e.st || InstrCount_o !== e.cnt)
        $display("FAIL sw_seq step%0d: state=%0d cnt=%0d, want %0d/%0d", i, State_o, InstrCount_o, e.st, e.cnt);
      else n_pass++;
      if (MemWrite_o === 1'b1) mw_cycles++;
      if (sts[i] == 0) begin
        n_checks++;
        if (IRWrite_o !== rdy[i][0] || PCWrite_o !== rdy[i][0])
          $display("FAIL fetch_stall step%0d: irw=%b pcw=%b, want %b", i, IRWrite_o, PCWrite_o, rdy[i][0]);
        else n_pass++;
      end
      if (sts[i] == 5) begin
        n_checks++;
        if (MemWrite_o !== 1'b1 || IorD_o !== 1'b1)
          $display("FAIL sw_memwr step%0d: memwrite=%b iord=%b, want 1/1", i, MemWrite_o, IorD_o);
        else n_pass++;
      end
      @(negedge clk);
    end
    n_checks++;
    if (mw_cycles != 4) $display("FAIL sw_hold: memwrite cycles=%0d, want 4", mw_cycles);
    else n_pass++;
    cnt_base += 1;
  endtask

  task automatic test_mixed();
    int sts[$]; int dc[$]; logic [5:0] ops[$]; exp_t e;
    sts = '{0, 1, 6, 7, 0, 1, 10, 11, 0, 1, 8, 0, 1, 9, 0};
    dc  = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 3, 3, 3, 4};
    ops = '{6'b000000, 6'b000000, 6'b000000, 6'b000000,
            6'b001000, 6'b001000, 6'b001000, 6'b001000,
            6'b000100, 6'b000100, 6'b000100,
            6'b000010, 6'b000010, 6'b000010, 6'b000010};
    foreach (sts[i]) begin
      op = ops[i];
      mem_ready = (i != sts.size() - 1);
      sb.push_back(exp_t'{st: 4'(sts[i]), cnt: CNT_W'(cnt_base + dc[i])});
      #1;
      e = sb.pop_front();
      n_checks++;
      if (State_o !== e.st || InstrCount_o !== e.cnt)
        $display("FAIL mix_seq step%0d: state=%0d cnt=%0d, want %0d/%0d", i, State_o, InstrCount_o, e.st, e.cnt);
      else n_pass++;
      case (sts[i])
        6: begin
          n_checks++;
          if (ALUOp_o !== 2'b11 || ALUSrcA_o !== 1'b1 || ALUSrcB_o !== 2'b00)
            $display("FAIL exec_ctl: aluop=%b srca=%b srcb=%b, want 11/1/00", ALUOp_o, ALUSrcA_o, ALUSrcB_o);
          else n_pass++;
        end
        7: begin
          n_checks++;
          if (RegDst_o !== 1'b1 || RegWrite_o !== 1'b1 || MemToReg_o !== 1'b0)
            $display("FAIL rwb_ctl: regdst=%b regwrite=%b memtoreg=%b, want 1/1/0", RegDst_o, RegWrite_o, MemToReg_o);
          else n_pass++;
        end
        10: begin
          n_checks++;
          if (ALUOp_o !== 2'b00 || ALUSrcB_o !== 2'b10 || ALUSrcA_o !== 1'b1)
            $display("FAIL addi_ctl: aluop=%b srcb=%b srca=%b, want 00/10/1", ALUOp_o, ALUSrcB_o, ALUSrcA_o);
          else n_pass++;
        end
        8: begin
          n_checks++;
          if (ALUOp_o !== 2'b01 || PCSource_o !== 2'b01 || PCWriteCond_o !== 1'b1 || PCWrite_o !== 1'b0)
            $display("FAIL beq_ctl: aluop=%b pcsrc=%b pcwc=%b pcw=%b, want 01/01/1/0",
                     ALUOp_o, PCSource_o, PCWriteCond_o, PCWrite_o);
          else n_pass++;
        end
        9: begin
          n_checks++;
          if (PCSource_o !== 2'b10 || PCWrite_o !== 1'b1)
            $display("FAIL j_ctl: pcsrc=%b pcw=%b, want 10/1", PCSource_o, PCWrite_o);
          else n_pass++;
        end
        1: begin
          n_checks++;
          if (ALUSrcB_o !== 2'b11 || ALUOp_o !== 2'b00 || RegWrite_o !== 1'b0)
            $display("FAIL decode_ctl: srcb=%b aluop=%b regwrite=%b, want 11/00/0", ALUSrcB_o, ALUOp_o, RegWrite_o);
          else n_pass++;
        end
        default: ;
      endcase
      @(negedge clk);
    end
    cnt_base += 4;
  endtask

  task automatic test_illegal();
    int sts[$]; int dc[$]; exp_t e;
`ifdef RV_TRAP_EN
    sts = '{0, 1, 12, 12, 12, 12, 12, 12, 12, 12, 12, 12};
    dc  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`else
    sts = '{0, 1, 0};
    dc  = '{0, 0, 1};
`endif
    op = 6'b111111;
    foreach (sts[i]) begin
      mem_ready = (i != sts.size() - 1);
      sb.push_back(exp_t'{st: 4'(sts[i]), cnt: CNT_W'(cnt_base + dc[i])});
      #1;
      e = sb.pop_front();
      n_checks++;
      if (State_o !== e.st || InstrCount_o !== e.cnt)
        $display("FAIL illegal_seq step%0d: state=%0d cnt=%0d, want %0d/%0d", i, State_o, InstrCount_o, e.st, e.cnt);
      else n_pass++;
      n_checks++;
      if (Trap_o !== (sts[i] == 12) || (sts[i] == 12 && (MemRead_o | PCWrite_o | RegWrite_o | MemWrite_o) !== 1'b0))
        $display("FAIL trap_out step%0d: trap=%b memread=%b pcw=%b, want trap=%b strobes 0",
                 i, Trap_o, MemRead_o, PCWrite_o, sts[i] == 12);
      else n_pass++;
      @(negedge clk);
    end
`ifdef RV_TRAP_EN
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0; #1;
    n_checks++;
    if (State_o !== 4'd0 || Trap_o !== 1'b0 || InstrCount_o !== '0)
      $display("FAIL trap_exit: state=%0d trap=%b cnt=%0d, want 0/0/0", State_o, Trap_o, InstrCount_o);
    else n_pass++;
    cnt_base = 0;
    @(negedge clk);
`else
    cnt_base += 1;
`endif
  endtask

  task automatic test_back_to_back();
    int sts[$]; int dc[$]; exp_t e;
    sts = '{0, 1, 9, 0, 1, 9, 0, 1, 9, 0};
    dc  = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
    op = 6'b000010;
    foreach (sts[i]) begin
      mem_ready = (i != sts.size() - 1);
      sb.push_back(exp_t'{st: 4'(sts[i]), cnt: CNT_W'(cnt_base + dc[i])});
      #1;
      e = sb.pop_front();
      n_checks++;
      if (State_o !== e.st || InstrCount_o !== e.cnt)
        $display("FAIL b2b_seq step%0d: state=%0d cnt=%0d, want %0d/%0d", i, State_o, InstrCount_o, e.st, e.cnt);
      else n_pass++;
      @(negedge clk);
    end
    cnt_base += 3;
  endtask

  task automatic test_reset_in_write();
    int sts[$]; exp_t e;
    sts = '{0, 1, 2};
    op = 6'b101011;
    foreach (sts[i]) begin
      mem_ready = 1'b1;
      sb.push_back(exp_t'{st: 4'(sts[i]), cnt: CNT_W'(cnt_base)});
      #1;
      e = sb.pop_front();
      n_checks++;
      if (State_o !== e.st || InstrCount_o !== e.cnt)
        $display("FAIL rstwr_seq step%0d: state=%0d cnt=%0d, want %0d/%0d", i, State_o, InstrCount_o, e.st, e.cnt);
      else n_pass++;
      @(negedge clk);
    end
    mem_ready = 1'b1; #1;
    n_checks++;
    if (State_o !== 4'd5 || MemWrite_o !== 1'b1)
      $display("FAIL rstwr_pre: state=%0d memwrite=%b, want 5/1", State_o, MemWrite_o);
    else n_pass++;
    rst_n = 1'b0; #1;
    n_checks++;
    if (MemWrite_o !== 1'b0)
      $display("FAIL rstwr_gate: memwrite=%b, want 0", MemWrite_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1; mem_ready = 1'b0; #1;
    n_checks++;
    if (State_o !== 4'd0 || InstrCount_o !== '0 || MemWrite_o !== 1'b0)
      $display("FAIL rstwr_after: state=%0d cnt=%0d memwrite=%b, want 0/0/0", State_o, InstrCount_o, MemWrite_o);
    else n_pass++;
    cnt_base = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_mixed();
    test_illegal();
    test_back_to_back();
    test_reset_in_write();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
